// File: rtl/me_pkg.sv
// Shared constants for the motion-estimation search controller family.
// Default geometry, FSM state codes and an index-width helper.
package me_pkg;

  localparam int DEF_SAD_W    = 14;
  localparam int DEF_NUM_PE   = 16;
  localparam int DEF_NUM_COLS = 16;
  localparam int DEF_FILL_CYC = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_SEARCH = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Index width for n items; a single item still gets a 1-bit field.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/me_min_tree.sv
// Combinational argmin over NUM_PE packed SADs; lowest index wins ties.
// Ports: sad_in (row r at [r*SAD_W +: SAD_W]) -> min_val, min_idx.
module me_min_tree #(
  parameter int NUM_PE = 16,
  parameter int SAD_W  = 14,
  parameter int IDX_W  = 4
) (
  input  logic [NUM_PE*SAD_W-1:0] sad_in,
  output logic [SAD_W-1:0]        min_val,
  output logic [IDX_W-1:0]        min_idx
);

  // Strict less-than while scanning upward keeps the lowest row on ties.
  always_comb begin
    min_val = sad_in[SAD_W-1:0];
    min_idx = '0;
    for (int r = 1; r < NUM_PE; r++) begin
      if (sad_in[r*SAD_W +: SAD_W] < min_val) begin
        min_val = sad_in[r*SAD_W +: SAD_W];
        min_idx = IDX_W'(r);
      end
    end
  end

endmodule

// File: rtl/me_search_ctrl.sv
// Motion-estimation search controller: PE fill, column sweep, global argmin.
// Ports: clk, rst_n, start, abort, sad_in -> crt_keep, busy,
//        res_valid/res_ready handshake, sad_min, mv_x, mv_y.
module me_search_ctrl
  import me_pkg::*;
#(
  parameter  int NUM_PE     = DEF_NUM_PE,
  parameter  int SAD_W      = DEF_SAD_W,
  parameter  int FILL_CYC   = DEF_FILL_CYC,
  parameter  int NUM_COLS   = DEF_NUM_COLS,
  parameter  int TIE_NEWEST = 0,
  localparam int MVY_W      = clog2_min1(NUM_PE),
  localparam int MVX_W      = clog2_min1(NUM_COLS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_PE*SAD_W-1:0] sad_in,
  output logic                    crt_keep,
  output logic                    busy,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [SAD_W-1:0]        sad_min,
  output logic [MVX_W-1:0]        mv_x,
  output logic [MVY_W-1:0]        mv_y
);

  // One counter serves both FILL and SEARCH, so size it for the longer.
  localparam int CNT_MAX =
    (FILL_CYC > NUM_COLS) ? FILL_CYC : NUM_COLS;
  localparam int CNT_W = clog2_min1(CNT_MAX);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SAD_W-1:0] run_min_q, run_min_d;
  logic [MVX_W-1:0] run_x_q, run_x_d;
  logic [MVY_W-1:0] run_y_q, run_y_d;

  logic [SAD_W-1:0] out_min_q, out_min_d;
  logic [MVX_W-1:0] out_x_q, out_x_d;
  logic [MVY_W-1:0] out_y_q, out_y_d;

  logic [SAD_W-1:0] col_min;
  logic [MVY_W-1:0] col_row;
  logic             fill_last;
  logic             col_last;
  logic             better;
  logic             take;
  logic [MVX_W-1:0] cur_x;

  me_min_tree #(
    .NUM_PE (NUM_PE),
    .SAD_W  (SAD_W),
    .IDX_W  (MVY_W)
  ) u_min_tree (
    .sad_in  (sad_in),
    .min_val (col_min),
    .min_idx (col_row)
  );

  assign fill_last = (cnt_q == CNT_W'(FILL_CYC - 1));
  assign col_last  = (cnt_q == CNT_W'(NUM_COLS - 1));
  assign cur_x     = MVX_W'(cnt_q);

  assign better = (TIE_NEWEST != 0) ? (col_min <= run_min_q)
                                    : (col_min <  run_min_q);

  // Column 0 always loads so an all-ones search keeps its real vector.
  assign take = (cnt_q == '0) || better;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_min_d = run_min_q;
    run_x_d   = run_x_q;
    run_y_d   = run_y_q;
    out_min_d = out_min_q;
    out_x_d   = out_x_q;
    out_y_d   = out_y_q;

    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_FILL;
            cnt_d   = '0;
          end
        end
        ST_FILL: begin
          if (fill_last) begin
            state_d = ST_SEARCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SEARCH: begin
          if (take) begin
            run_min_d = col_min;
            run_x_d   = cur_x;
            run_y_d   = col_row;
          end
          if (col_last) begin
            // Publish including this final column's update.
            state_d   = ST_HOLD;
            cnt_d     = '0;
            out_min_d = run_min_d;
            out_x_d   = run_x_d;
            out_y_d   = run_y_d;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      run_min_q <= '1;
      run_x_q   <= '0;
      run_y_q   <= '0;
      out_min_q <= '1;
      out_x_q   <= '0;
      out_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_min_q <= run_min_d;
      run_x_q   <= run_x_d;
      run_y_q   <= run_y_d;
      out_min_q <= out_min_d;
      out_x_q   <= out_x_d;
      out_y_q   <= out_y_d;
    end
  end

  assign crt_keep  = (state_q == ST_SEARCH);
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_HOLD);
  assign sad_min   = out_min_q;
  assign mv_x      = out_x_q;
  assign mv_y      = out_y_q;

endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed bench for me_search_ctrl: default, tie-newest and small variants.
// Column SADs come from a shared table indexed by the current column.
module tb_me_search_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_ab, abort_ab, rdy_ab;
  logic start_c, abort_c, rdy_c;

  logic [13:0] tab [16][16];
  logic [3:0]  col_sel;

  logic [16*14-1:0] sad_ab;
  logic [4*14-1:0]  sad_c;

  always_comb begin
    sad_ab = '0;
    sad_c  = '0;
    for (int r = 0; r < 16; r++)
      sad_ab[r*14 +: 14] = tab[col_sel][r];
    for (int r = 0; r < 4; r++)
      sad_c[r*14 +: 14] = tab[col_sel][r];
  end

  logic        keep_a, busy_a, val_a;
  logic [13:0] min_a;
  logic [3:0]  x_a, y_a;
  logic        keep_b, busy_b, val_b;
  logic [13:0] min_b;
  logic [3:0]  x_b, y_b;
  logic        keep_c, busy_c, val_c;
  logic [13:0] min_c;
  logic [2:0]  x_c;
  logic [1:0]  y_c;

  me_search_ctrl u_a (
    .clk(clk), .rst_n(rst_n),
    .start(start_ab), .abort(abort_ab),
    .sad_in(sad_ab), .crt_keep(keep_a),
    .busy(busy_a), .res_valid(val_a),
    .res_ready(rdy_ab), .sad_min(min_a),
    .mv_x(x_a), .mv_y(y_a)
  );

  me_search_ctrl #(.TIE_NEWEST(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .start(start_ab), .abort(abort_ab),
    .sad_in(sad_ab), .crt_keep(keep_b),
    .busy(busy_b), .res_valid(val_b),
    .res_ready(rdy_ab), .sad_min(min_b),
    .mv_x(x_b), .mv_y(y_b)
  );

  me_search_ctrl #(
    .NUM_PE(4), .NUM_COLS(8), .FILL_CYC(3)
  ) u_c (
    .clk(clk), .rst_n(rst_n),
    .start(start_c), .abort(abort_c),
    .sad_in(sad_c), .crt_keep(keep_c),
    .busy(busy_c), .res_valid(val_c),
    .res_ready(rdy_c), .sad_min(min_c),
    .mv_x(x_c), .mv_y(y_c)
  );

  int n_chk = 0;
  int n_fail = 0;
  int keep_cnt;
  int first_keep;
  int early_val;
  int bad;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic fill_tab(input logic [13:0] v);
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < 16; r++)
        tab[c][r] = v;
  endtask

  // Pulse start, then run n edges feeding column k-1-fill
  // during the cycle that ends at edge k.
  task automatic go(input bit sel, input int fill,
                    input int n);
    int c;
    logic kp, vl;
    keep_cnt   = 0;
    first_keep = -1;
    early_val  = 0;
    @(negedge clk);
    if (sel) start_c = 1'b1;
    else     start_ab = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      start_ab = 1'b0;
      start_c  = 1'b0;
      c = k - 1 - fill;
      col_sel = (c < 0) ? 4'd0 : 4'(c);
      kp = sel ? keep_c : keep_a;
      vl = sel ? val_c : val_a;
      if (kp) begin
        keep_cnt++;
        if (first_keep < 0) first_keep = k - 1;
      end
      if (vl) early_val++;
      @(posedge clk);
    end
  endtask

  task automatic ack_ab();
    @(negedge clk);
    rdy_ab = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdy_ab = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start_ab = 0; abort_ab = 0; rdy_ab = 0;
    start_c = 0;  abort_c = 0;  rdy_c = 0;
    col_sel = 4'd0;
    fill_tab(14'd500);

    repeat (2) @(negedge clk);
    check("rst_keep", 32'(keep_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_valid", 32'(val_a), 0);
    check("rst_min", 32'(min_a), 16383);
    check("rst_x", 32'(x_a), 0);
    check("rst_y", 32'(y_a), 0);
    rst_n = 1'b1;

    // Single minimum at column 5 row 9.
    fill_tab(14'd500);
    tab[5][9] = 14'd12;
    go(0, 8, 24);
    check("t1_keep_cnt", 32'(keep_cnt), 16);
    check("t1_keep_first", 32'(first_keep), 8);
    check("t1_early_valid", 32'(early_val), 0);
    @(negedge clk);
    check("t1_valid", 32'(val_a), 1);
    check("t1_min", 32'(min_a), 12);
    check("t1_x", 32'(x_a), 5);
    check("t1_y", 32'(y_a), 9);
    ack_ab();
    check("t1_ack_valid", 32'(val_a), 0);

    // Cross-column tie: older vs newer column.
    fill_tab(14'd500);
    tab[3][2]  = 14'd7;
    tab[11][0] = 14'd7;
    go(0, 8, 24);
    @(negedge clk);
    check("tie_old_min", 32'(min_a), 7);
    check("tie_old_x", 32'(x_a), 3);
    check("tie_old_y", 32'(y_a), 2);
    check("tie_new_min", 32'(min_b), 7);
    check("tie_new_x", 32'(x_b), 11);
    check("tie_new_y", 32'(y_b), 0);
    ack_ab();

    // Row tie inside one column picks the lower row.
    fill_tab(14'd500);
    tab[4][6] = 14'd30;
    tab[4][1] = 14'd30;
    go(0, 8, 24);
    @(negedge clk);
    check("rowtie_min", 32'(min_a), 30);
    check("rowtie_x", 32'(x_a), 4);
    check("rowtie_y", 32'(y_a), 1);
    ack_ab();

    // All-ones SADs, then stall in HOLD with a stray start.
    fill_tab(14'h3fff);
    go(0, 8, 24);
    @(negedge clk);
    check("ones_valid", 32'(val_a), 1);
    check("ones_min", 32'(min_a), 16383);
    check("ones_x", 32'(x_a), 0);
    check("ones_y", 32'(y_a), 0);
    bad = 0;
    fill_tab(14'd3);
    for (int i = 0; i < 10; i++) begin
      start_ab = (i == 4);
      @(posedge clk);
      @(negedge clk);
      if (!val_a || min_a != 14'h3fff ||
          x_a != 4'd0 || y_a != 4'd0)
        bad++;
    end
    start_ab = 1'b0;
    check("hold_stable", 32'(bad), 0);
    rdy_ab = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdy_ab = 1'b0;
    check("hold_ack_valid", 32'(val_a), 0);
    check("hold_ack_busy", 32'(busy_a), 0);
    start_ab = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_ab = 1'b0;
    check("restart_busy", 32'(busy_a), 1);
    abort_ab = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort_ab = 1'b0;
    check("abort_fill_busy", 32'(busy_a), 0);
    check("abort_fill_min", 32'(min_a), 16383);

    // Prior result (20,1,1), then abort at column 6.
    fill_tab(14'd500);
    tab[1][1] = 14'd20;
    go(0, 8, 24);
    ack_ab();
    check("pre_abort_min", 32'(min_a), 20);
    fill_tab(14'd5);
    go(0, 8, 14);
    @(negedge clk);
    col_sel = 4'd6;
    check("ab_keep_before", 32'(keep_a), 1);
    abort_ab = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort_ab = 1'b0;
    check("ab_busy", 32'(busy_a), 0);
    check("ab_keep", 32'(keep_a), 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (val_a || busy_a) bad++;
    end
    check("ab_no_valid", 32'(bad), 0);
    check("ab_min", 32'(min_a), 20);
    check("ab_x", 32'(x_a), 1);
    check("ab_y", 32'(y_a), 1);

    // Small variant: 4 rows, 8 columns, 3 fill cycles.
    fill_tab(14'd500);
    tab[6][3] = 14'd9;
    go(1, 3, 11);
    check("c_keep_cnt", 32'(keep_cnt), 8);
    check("c_keep_first", 32'(first_keep), 3);
    check("c_early_valid", 32'(early_val), 0);
    @(negedge clk);
    check("c_valid", 32'(val_c), 1);
    check("c_min", 32'(min_c), 9);
    check("c_x", 32'(x_c), 6);
    check("c_y", 32'(y_c), 3);
    rdy_c = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdy_c = 1'b0;

    // Asynchronous reset in the middle of a search.
    go(1, 3, 6);
    @(negedge clk);
    check("c_mid_keep", 32'(keep_c), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_c), 0);
    check("arst_keep", 32'(keep_c), 0);
    check("arst_min", 32'(min_c), 16383);
    check("arst_x", 32'(x_c), 0);
    check("arst_y", 32'(y_c), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
